peridot_servo_ramp: RTL and testbench

PERIDOT_SERVO_RAMP -- requirements
Module: peridot_servo_ramp

---
 rtl/peridot_servo_ramp.sv | 224 ++++++++++++++++++++++
 tb/tb_peridot_servo_ramp.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peridot_servo_ramp.sv
// Servo ramp sequencer: once per frame, steps every channel's position toward
// its target and pushes the new positions into the servo register block.
module peridot_servo_ramp #(
    parameter int CHANNEL_NUM = 8,
    parameter int CLOCKFREQ   = 25000000,
    parameter int FRAME_HZ    = 50
) (
    input  logic        csi_clk,
    input  logic        rsi_reset,
    input  logic [3:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [4:0]  avm_address,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest
);
    localparam logic [23:0] RELOAD = 24'(CLOCKFREQ / FRAME_HZ - 1);
    localparam int IW = 3;
    localparam logic [IW-1:0] LAST = IW'(CHANNEL_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_CALC, S_WRITE, S_NEXT, S_SHUT
    } state_t;

    state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic en_q, en_d, busy_q, busy_d, ovr_q, ovr_d;
    logic pend_q, pend_d, first_q, first_d, shut_q, shut_d;
    logic [23:0] timer_q, timer_d;
    logic [15:0] frame_q, frame_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0] target_q [CHANNEL_NUM];
    logic [7:0] target_d [CHANNEL_NUM];
    logic [7:0] step_q [CHANNEL_NUM];
    logic [7:0] step_d [CHANNEL_NUM];
    logic [7:0] current_q [CHANNEL_NUM];
    logic [7:0] current_d [CHANNEL_NUM];

    logic [3:0] chan_sel;
    logic [IW-1:0] ch;
    logic chan_hit, ctrl_wr, en_rise, en_fall, tick, consume, settled;
    logic [7:0] r_cur, r_tgt, r_stp, r_next;
    logic unused_bits;

    assign chan_sel = avs_address - 4'd2;
    assign ch = chan_sel[IW-1:0];
    assign chan_hit = (avs_address >= 4'd2)
        && ({1'b0, avs_address} < 5'(CHANNEL_NUM + 2));
    assign ctrl_wr = avs_write && (avs_address == 4'd0);
    assign en_rise = ctrl_wr && avs_writedata[0] && !en_q;
    assign en_fall = ctrl_wr && !avs_writedata[0] && en_q;
    assign tick = en_q && (timer_q == 24'd0);
    assign consume = (state_q == S_IDLE) && !shut_q && pend_q && en_q;
    assign avs_readdata = rdata_q;
    assign unused_bits = ^{avs_writedata[31:16], chan_sel[3]};

    always_comb begin
        settled = 1'b1;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (current_q[i] != target_q[i]) settled = 1'b0;
        end
    end

    // Move toward the target by at most one step, landing exactly on it.
    always_comb begin
        r_cur = current_q[idx_q];
        r_tgt = target_q[idx_q];
        r_stp = step_q[idx_q];
        r_next = r_tgt;
        if (r_stp != 8'd0 && r_cur < r_tgt && (r_tgt - r_cur) > r_stp)
            r_next = r_cur + r_stp;
        else if (r_stp != 8'd0 && r_cur > r_tgt && (r_cur - r_tgt) > r_stp)
            r_next = r_cur - r_stp;
    end

    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        busy_d = busy_q;
        first_d = first_q;
        shut_d = shut_q;
        frame_d = frame_q;
        en_d = en_q;
        ovr_d = ovr_q;
        pend_d = pend_q;
        timer_d = timer_q;
        target_d = target_q;
        step_d = step_q;
        current_d = current_q;
        avm_write = 1'b0;
        avm_address = 5'd0;
        avm_writedata = 32'd0;

        unique case (state_q)
            S_IDLE: begin
                if (shut_q) begin
                    state_d = S_SHUT;
                end else if (consume) begin
                    busy_d = 1'b1;
                    idx_d = '0;
                    first_d = 1'b0;
                    state_d = first_q ? S_INIT : S_CALC;
                end
            end
            S_INIT: begin
                avm_write = 1'b1;
                avm_writedata = 32'd1;
                if (!avm_waitrequest) state_d = S_CALC;
            end
            S_CALC: begin
                current_d[idx_q] = r_next;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                avm_write = 1'b1;
                avm_address = 5'(idx_q) + 5'd2;
                avm_writedata = {24'd0, current_q[idx_q]};
                if (!avm_waitrequest) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (idx_q == LAST) begin
                    frame_d = frame_q + 16'd1;
                    busy_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + IW'(1);
                    state_d = S_CALC;
                end
            end
            S_SHUT: begin
                avm_write = 1'b1;
                if (!avm_waitrequest) begin
                    shut_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (ctrl_wr) begin
            en_d = avs_writedata[0];
            if (avs_writedata[3]) ovr_d = 1'b0;
        end
        if (avs_write && chan_hit) begin
            target_d[ch] = avs_writedata[7:0];
            step_d[ch] = avs_writedata[15:8];
        end

        if (en_rise) timer_d = RELOAD;
        else if (tick) timer_d = RELOAD;
        else if (en_q) timer_d = timer_q - 24'd1;

        // A tick landing on an unconsumed request is lost.
        if (consume) pend_d = 1'b0;
        if (tick) begin
            if (pend_q && !consume) ovr_d = 1'b1;
            pend_d = 1'b1;
        end
        if (en_rise) begin
            pend_d = 1'b1;
            first_d = 1'b1;
            shut_d = 1'b0;
        end
        if (en_fall) begin
            pend_d = 1'b0;
            shut_d = 1'b1;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (avs_read) begin
            unique case (1'b1)
                (avs_address == 4'd0):
                    rdata_d = {28'd0, ovr_q, settled, busy_q, en_q};
                (avs_address == 4'd1):
                    rdata_d = {16'd0, frame_q};
                chan_hit:
                    rdata_d = {8'd0, current_q[ch], step_q[ch], target_q[ch]};
                default:
                    rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            state_q <= S_IDLE;
            idx_q <= '0;
            en_q <= 1'b0;
            busy_q <= 1'b0;
            ovr_q <= 1'b0;
            pend_q <= 1'b0;
            first_q <= 1'b0;
            shut_q <= 1'b0;
            timer_q <= 24'd0;
            frame_q <= 16'd0;
            rdata_q <= 32'd0;
            for (int i = 0; i < CHANNEL_NUM; i++) begin
                target_q[i] <= 8'h80;
                step_q[i] <= 8'h00;
                current_q[i] <= 8'h80;
            end
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            en_q <= en_d;
            busy_q <= busy_d;
            ovr_q <= ovr_d;
            pend_q <= pend_d;
            first_q <= first_d;
            shut_q <= shut_d;
            timer_q <= timer_d;
            frame_q <= frame_d;
            rdata_q <= rdata_d;
            target_q <= target_d;
            step_q <= step_d;
            current_q <= current_d;
        end
    end
endmodule

// File: tb/tb_peridot_servo_ramp.sv
// Bench for peridot_servo_ramp: register vectors, frame-level ramp model,
// stall, overrun, disable and reset corner cases.
module tb_peridot_servo_ramp;
    localparam int NCH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [4:0]  avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        wait_rq = 1'b0;

    peridot_servo_ramp #(
        .CHANNEL_NUM(NCH),
        .CLOCKFREQ(100),
        .FRAME_HZ(1)
    ) dut (
        .csi_clk(clk),
        .rsi_reset(rst),
        .avs_address(avs_address),
        .avs_read(avs_read),
        .avs_readdata(avs_readdata),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .avm_address(avm_address),
        .avm_write(avm_write),
        .avm_writedata(avm_writedata),
        .avm_waitrequest(wait_rq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } mw_t;
    mw_t q[$];

    // Every accepted master write, seen half a cycle before its edge.
    always @(negedge clk) begin
        if (!rst && avm_write && !wait_rq)
            q.push_back('{addr: avm_address, data: avm_writedata});
    end

    int n_checks = 0;
    int n_fail = 0;
    int m_cur[NCH];
    int m_tgt[NCH];
    int m_stp[NCH];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wr(logic [3:0] a, logic [31:0] d);
        @(posedge clk);
        #1;
        avs_address = a;
        avs_writedata = d;
        avs_write = 1'b1;
        @(posedge clk);
        #1;
        avs_write = 1'b0;
    endtask

    task automatic rd(logic [3:0] a, output logic [31:0] d);
        @(posedge clk);
        #1;
        avs_address = a;
        avs_read = 1'b1;
        @(posedge clk);
        #1;
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    function automatic int ramp(int cur, int tgt, int stp);
        int diff;
        diff = tgt - cur;
        if (stp == 0 || (diff <= stp && diff >= -stp)) return tgt;
        return (diff > 0) ? cur + stp : cur - stp;
    endfunction

    function automatic logic all_settled();
        for (int c = 0; c < NCH; c++)
            if (m_cur[c] != m_tgt[c]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic set_ch(int c, int tgt, int stp);
        m_tgt[c] = tgt;
        m_stp[c] = stp;
        wr(4'(c + 2), {16'd0, 8'(stp), 8'(tgt)});
    endtask

    task automatic wait_writes(int n, int budget, string tag);
        int k;
        k = 0;
        while (q.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk({tag, " timeout"}, 32'(q.size() >= n), 32'd1);
    endtask

    task automatic run_frame(string tag);
        mw_t e;
        wait_writes(NCH, 400, tag);
        for (int c = 0; c < NCH; c++) begin
            m_cur[c] = ramp(m_cur[c], m_tgt[c], m_stp[c]);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({tag, " addr"}, 32'(e.addr), 32'(c + 2));
                chk({tag, " data"}, e.data, 32'(m_cur[c]));
            end
        end
    endtask

    typedef struct {
        bit          is_wr;
        logic [3:0]  addr;
        logic [31:0] data;
    } reg_vec_t;

    typedef struct {
        logic [7:0] exp_ch0;
        logic       exp_settled;
    } ramp_vec_t;

    initial begin
        reg_vec_t rv[12];
        ramp_vec_t fv[5];
        logic [31:0] r;
        logic [4:0] a0;
        logic [31:0] d0;
        mw_t e;
        int bad, k;

        rv = '{
            '{0, 4'd0, 32'h0000_0004},
            '{0, 4'd1, 32'h0000_0000},
            '{0, 4'd2, 32'h0080_0080},
            '{1, 4'd9, 32'h0000_1234},
            '{0, 4'd9, 32'h0080_1234},
            '{0, 4'd0, 32'h0000_0000},
            '{1, 4'd12, 32'h0000_ffff},
            '{0, 4'd12, 32'h0000_0000},
            '{0, 4'd10, 32'h0000_0000},
            '{1, 4'd9, 32'h0000_0080},
            '{0, 4'd9, 32'h0080_0080},
            '{0, 4'd0, 32'h0000_0004}
        };
        fv = '{
            '{8'h85, 1'b0},
            '{8'h8A, 1'b0},
            '{8'h8F, 1'b0},
            '{8'h90, 1'b1},
            '{8'h90, 1'b1}
        };
        for (int c = 0; c < NCH; c++) begin
            m_cur[c] = 8'h80;
            m_tgt[c] = 8'h80;
            m_stp[c] = 0;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("reset avm_write", 32'(avm_write), 32'd0);
        chk("reset avm_address", 32'(avm_address), 32'd0);
        chk("reset avm_writedata", avm_writedata, 32'd0);
        chk("reset avs_readdata", avs_readdata, 32'd0);
        rst = 1'b0;

        foreach (rv[i]) begin
            if (rv[i].is_wr) wr(rv[i].addr, rv[i].data);
            else begin
                rd(rv[i].addr, r);
                chk($sformatf("regvec %0d", i), r, rv[i].data);
            end
        end

        // First scan after enable starts with the servo enable write.
        wr(4'd0, 32'd1);
        wait_writes(NCH + 1, 400, "enable");
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("init addr", 32'(e.addr), 32'd0);
            chk("init data", e.data, 32'd1);
        end
        run_frame("frame0");
        repeat (3) @(posedge clk);
        rd(4'd0, r);
        chk("ctrl after frame0", r, 32'h5);
        rd(4'd1, r);
        chk("frame count 1", r, 32'd1);

        set_ch(0, 8'h90, 5);
        set_ch(1, 8'h10, 0);
        foreach (fv[i]) begin
            run_frame($sformatf("ramp%0d", i));
            chk($sformatf("ramp%0d ch0 table", i), 32'(m_cur[0]),
                32'(fv[i].exp_ch0));
            chk($sformatf("ramp%0d ch1", i), 32'(m_cur[1]), 32'h10);
            rd(4'd0, r);
            chk($sformatf("ramp%0d settled", i), 32'(r[2]),
                32'(fv[i].exp_settled));
        end
        rd(4'd1, r);
        chk("frame count 6", r, 32'd6);

        // Hold the first write of a frame under waitrequest.
        wait_rq = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!avm_write && k < 300);
        chk("stall write seen", 32'(avm_write), 32'd1);
        a0 = avm_address;
        d0 = avm_writedata;
        chk("stall addr", 32'(a0), 32'd2);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (avm_write !== 1'b1 || avm_address !== a0 ||
                avm_writedata !== d0) bad++;
        end
        chk("stall stable", 32'(bad), 32'd0);
        @(posedge clk);
        #1;
        wait_rq = 1'b0;
        run_frame("stall frame");
        repeat (5) @(posedge clk);
        chk("no duplicate", 32'(q.size()), 32'd0);

        for (int round = 0; round < 4; round++) begin
            for (int c = 0; c < NCH; c++)
                set_ch(c, $urandom_range(0, 255), $urandom_range(0, 48));
            run_frame($sformatf("rand%0d", round));
            rd(4'd0, r);
            chk($sformatf("rand%0d settled", round), 32'(r[2]),
                32'(all_settled()));
        end

        for (int c = 0; c < NCH; c++)
            set_ch(c, $urandom_range(0, 255), 0);
        run_frame("settle");

        // Stall long enough for two ticks to stack up.
        wait_rq = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!avm_write && k < 300);
        repeat (250) @(posedge clk);
        #1;
        wait_rq = 1'b0;
        repeat (150) @(posedge clk);
        chk("overrun writes", 32'(q.size() >= NCH), 32'd1);
        bad = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.addr < 5'd2 || e.addr > 5'(NCH + 1)) bad++;
            else if (e.data != 32'(m_cur[e.addr - 5'd2])) bad++;
        end
        chk("overrun write values", 32'(bad), 32'd0);
        rd(4'd0, r);
        chk("overrun set", 32'(r[3]), 32'd1);
        wr(4'd0, 32'h9);
        rd(4'd0, r);
        chk("overrun cleared", 32'(r[3]), 32'd0);
        chk("enable kept", 32'(r[0]), 32'd1);

        // Disable after the second channel of a scan has gone out.
        q.delete();
        k = 0;
        while (k < 300) begin
            @(posedge clk);
            k++;
            while (q.size() > 0 && q[0].addr != 5'd2) void'(q.pop_front());
            if (q.size() >= 2) break;
        end
        chk("mid-scan reached", 32'(q.size() >= 2), 32'd1);
        wr(4'd0, 32'd0);
        repeat (300) @(posedge clk);
        chk("disable write count", 32'(q.size()), 32'(NCH + 1));
        for (int c = 0; c < NCH; c++) begin
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("disable ch addr", 32'(e.addr), 32'(c + 2));
                chk("disable ch data", e.data, 32'(m_cur[c]));
            end
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("shut addr", 32'(e.addr), 32'd0);
            chk("shut data", e.data, 32'd0);
        end
        rd(4'd0, r);
        chk("ctrl disabled", r & 32'h3, 32'd0);

        // Re-enable, then reset in the middle of the stalled init write.
        wait_rq = 1'b1;
        wr(4'd0, 32'd1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!avm_write && k < 300);
        chk("reinit addr", 32'(avm_address), 32'd0);
        chk("reinit data", avm_writedata, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("reset drops avm_write", 32'(avm_write), 32'd0);
        chk("reset clears readdata", avs_readdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_rq = 1'b0;
        q.delete();
        repeat (300) @(posedge clk);
        chk("quiet after reset", 32'(q.size()), 32'd0);
        rd(4'd0, r);
        chk("ctrl after reset", r, 32'h4);
        rd(4'd1, r);
        chk("frame after reset", r, 32'd0);
        rd(4'd2, r);
        chk("ch0 after reset", r, 32'h0080_0080);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
